mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Sequencing controller for the multiply/divide resource in the E stage of the 5-stage core.
- Accepts start/op/operands from E stage; models multi-cycle mult/div latency with a down-counter and FSM; holds HI/LO architectural registers.
- Commits results to HI/LO at completion.
- Generates the busy and stall indications consumed by the D-stage hazard logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  clock.
- res  in  1  reset, asynchronous, active-low.
- start  in  1  E-stage MDU instruction valid this cycle.
- op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6,7 = no-op.
- a  in  32  rs operand (already forwarded).
- b  in  32  rt operand (already forwarded).
- md_req  in  1  D stage holds an MDU-class instruction (mult/div/mthi/mtlo/mfhi/mflo).
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse, high the cycle after HI/LO commit.
- stall  out  1  request to freeze F/D and bubble E.

Behaviour:
- Reset (res=0, async): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, shadow regs=0. Reset mid-operation discards the operation immediately.
- States:
  - IDLE:
    - start=1 and op in {0,1} -> MUL, counter=MULT_CYCLES-1.
    - start=1 and op in {2,3} -> DIV, counter=DIV_CYCLES-1.
    - On the start edge, compute the result combinationally from a/b and latch it into shadow HI/LO.
  - MUL/DIV:
    - Counter decrements each edge.
    - Edge where counter==0: hi/lo <= shadow, state -> IDLE, done=1 for the following cycle.
- busy = (state != IDLE). Registered; rises the cycle after the start edge and stays high exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). New hi/lo are visible in the same cycle busy falls.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: same, unsigned.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b==0): operation still occupies DIV_CYCLES busy cycles; hi/lo left unchanged at commit.
- mthi/mtlo:
  - In IDLE with start=1: hi (or lo) <= a at that edge; no busy, single cycle.
  - While busy: ignored.
- start while busy: ignored. The hazard logic guarantees this does not occur; a bench assertion flags it.
- stall = md_req & (busy | (start & op<=3)). Combinational, so mfhi/mflo behind a freshly started mult stalls from the start cycle.
- done never coincides with busy=1 unless a new start is accepted on the done cycle; that start is legal.
- op 6/7 with start=1: no state change.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit, placed after md_req), used for exception flush.
  - abort=1 in MUL/DIV: state -> IDLE next edge, shadow discarded, hi/lo unchanged, done not asserted.
  - abort=1 in the same cycle as start: the start is not accepted.
  - abort has priority over counter==0 commit.
- Undefined: no abort port; every accepted operation runs to completion.

Test Plan:
- Signed mult: a=32'hFFFFFFFD (-3), b=4, op=0, one-cycle start -> busy=1 for exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFF4; done pulses once.
- Unsigned and signed div:
  - divu a=7, b=2 -> after 10 busy cycles, lo=3, hi=1.
  - div a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- Divide by zero and mt ordering:
  - mthi a=32'h12345678 in IDLE -> hi updates next edge, busy stays 0.
  - Then div b=0 -> busy for 10 cycles; hi=32'h12345678 and lo unchanged afterwards.
- Stall:
  - md_req=1 in the start cycle of mult -> stall=1 that cycle and for all 5 busy cycles; stall=0 the cycle busy falls.
  - md_req=0 while busy -> stall=0.
- Reset mid-op: assert res=0 asynchronously at busy cycle 4 of a div -> busy, done, hi, lo go to 0 without waiting for clk; after release, a new mult completes normally.
- MDU_ABORT_EN build: abort at busy cycle 3 of a mult (prior hi=lo=0) -> busy=0 next edge, hi=lo=0, no done pulse; with MDU_ABORT_EN undefined, the same mult completes normally.

Source files
------------

// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - E-stage <-> multiply/divide sequencer signal bundle
// Optional abort line exists only when MDU_ABORT_EN is defined.
interface mdu_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_req;
`ifdef MDU_ABORT_EN
  logic        abort;
`endif
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

`ifdef MDU_ABORT_EN
  modport master (output start, op, a, b, md_req, abort,
                  input  hi, lo, busy, done, stall);
  modport slave  (input  start, op, a, b, md_req, abort,
                  output hi, lo, busy, done, stall);
`else
  modport master (output start, op, a, b, md_req,
                  input  hi, lo, busy, done, stall);
  modport slave  (input  start, op, a, b, md_req,
                  output hi, lo, busy, done, stall);
`endif
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle mult/div sequencer holding HI/LO, with busy/stall to hazard logic
// Optional exception-flush abort input enabled by defining MDU_ABORT_EN.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       res,
  mdu_seq_if.slave   bus
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        commit;
  logic        accept;
  logic        abort_w;

  logic [31:0] hi_q, lo_q;
  logic [31:0] shadow_hi, shadow_lo;
  logic        shadow_wr;
  logic        done_q;

  logic        is_mul, is_div;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic signed [31:0] sa, sb;
  logic [31:0] divisor;
  logic signed [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;
  logic [31:0] res_hi, res_lo;

`ifdef MDU_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  assign is_mul = (bus.op == 3'd0) || (bus.op == 3'd1);
  assign is_div = (bus.op == 3'd2) || (bus.op == 3'd3);
  assign accept = bus.start && (state == S_IDLE) && !abort_w;

  // Result is formed from the operands on the start edge; the counter only models latency.
  assign a_sx   = {{32{bus.a[31]}}, bus.a};
  assign b_sx   = {{32{bus.b[31]}}, bus.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  assign divisor = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign sa      = bus.a;
  assign sb      = divisor;
  assign q_s     = sa / sb;
  assign r_s     = sa % sb;
  assign q_u     = bus.a / divisor;
  assign r_u     = bus.a % divisor;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (bus.op)
      3'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      3'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      3'd2: begin res_hi = r_s;           res_lo = q_s;          end
      3'd3: begin res_hi = r_u;           res_lo = q_u;          end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_n = S_MUL;
          cnt_n   = CW'(MULT_CYCLES - 1);
        end else if (accept && is_div) begin
          state_n = S_DIV;
          cnt_n   = CW'(DIV_CYCLES - 1);
        end
      end
      S_MUL, S_DIV: begin
        // Flush wins over a commit due on the same edge.
        if (abort_w) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = S_IDLE;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      shadow_wr <= 1'b0;
    end else if (accept && (is_mul || is_div)) begin
      shadow_hi <= res_hi;
      shadow_lo <= res_lo;
      shadow_wr <= !(is_div && (bus.b == 32'd0));
    end else if (state != S_IDLE && abort_w) begin
      shadow_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit && shadow_wr) begin
        hi_q <= shadow_hi;
        lo_q <= shadow_lo;
      end else if (accept && bus.op == 3'd4) begin
        hi_q <= bus.a;
      end else if (accept && bus.op == 3'd5) begin
        lo_q <= bus.a;
      end
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  // Combinational so a dependent mfhi/mflo freezes from the very start cycle.
  assign bus.stall = bus.md_req && ((state != S_IDLE) || (bus.start && (bus.op <= 3'd3)));

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - randomized self-checking bench for mdu_seq against an arithmetic model
// Abort scenario is exercised when MDU_ABORT_EN is defined.
module tb_mdu_seq;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic res;
  int   vectors;
  int   miscompares;
  logic [31:0] mhi, mlo;

  mdu_seq_if bus ();

  mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(bus.start && bus.busy && res)) else $error("start issued while busy");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: architectural meaning of each op using magnitudes and 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          ps;
    longint unsigned pu;
    logic [31:0]     ax, ay, q, r;
    case (o)
      3'd0: begin
        ps  = longint'($signed(x)) * longint'($signed(y));
        mhi = ps[63:32]; mlo = ps[31:0];
      end
      3'd1: begin
        pu  = {32'd0, x} * {32'd0, y};
        mhi = pu[63:32]; mlo = pu[31:0];
      end
      3'd2: if (y != 0) begin
        ax = x[31] ? -x : x;
        ay = y[31] ? -y : y;
        q  = ax / ay;
        r  = ax % ay;
        mlo = (x[31] ^ y[31]) ? -q : q;
        mhi = x[31] ? -r : r;
      end
      3'd3: if (y != 0) begin
        mlo = x / y; mhi = x % y;
      end
      3'd4: mhi = x;
      3'd5: mlo = x;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic req);
    int n;
    int exp_n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.md_req = req;
    #1;
    check("stall_start", bus.stall, req & (o <= 3'd3));
    model(o, x, y);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (o <= 3'd3) begin
      exp_n = (o <= 3'd1) ? MC : DC;
      n = 0;
      while (bus.busy && n < 50) begin
        if (bus.stall !== req) check("stall_busy", bus.stall, req);
        if (bus.done !== 1'b0) check("done_early", bus.done, 0);
        n++;
        @(posedge clk); #1;
      end
      check("busy_cycles", n, exp_n);
      check("done_pulse", bus.done, 1);
      check("stall_after", bus.stall, 0);
    end else begin
      check("busy_none", bus.busy, 0);
      check("done_none", bus.done, 0);
    end
    check("hi", bus.hi, mhi);
    check("lo", bus.lo, mlo);
    bus.md_req = 1'b0;
    @(posedge clk); #1;
    check("done_clear", bus.done, 0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    vectors = 0; miscompares = 0;
    mhi = 0; mlo = 0;
    res = 1'b0;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.md_req = 0;
`ifdef MDU_ABORT_EN
    bus.abort = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    res = 1'b1;

    do_op(3'd0, 32'hFFFFFFFD, 32'd4, 1'b1);
    check("mult_hi_const", bus.hi, 32'hFFFFFFFF);
    check("mult_lo_const", bus.lo, 32'hFFFFFFF4);
    do_op(3'd3, 32'd7, 32'd2, 1'b0);
    check("divu_lo_const", bus.lo, 32'd3);
    check("divu_hi_const", bus.hi, 32'd1);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_const", bus.lo, 32'hFFFFFFFD);
    check("div_hi_const", bus.hi, 32'hFFFFFFFF);
    do_op(3'd4, 32'h12345678, 32'd0, 1'b0);
    do_op(3'd2, 32'd99, 32'd0, 1'b1);
    check("div0_hi_const", bus.hi, 32'h12345678);
    check("div0_lo_const", bus.lo, 32'hFFFFFFFD);
    do_op(3'd6, 32'hDEADBEEF, 32'd1, 1'b0);

    // Async reset in busy cycle 4 of a divide.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_pre_busy", bus.busy, 1);
    res = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    mhi = 0; mlo = 0;
    @(posedge clk); #1;
    res = 1'b1;

`ifdef MDU_ABORT_EN
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_busy", bus.busy, 1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    @(posedge clk); #1;
    check("abort_done2", bus.done, 0);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start_rej", bus.busy, 0);
    @(posedge clk); #1;
    check("abort_start_done", bus.done, 0);
`else
    do_op(3'd0, 32'd5, 32'd6, 1'b0);
    check("noabort_lo", bus.lo, 32'd30);
`endif
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (($urandom_range(0, 3) == 0)) y = y & 32'h0000000F;
      if (o == 3'd2 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
      do_op(o, x, y, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
